// File: rtl/ramio_lsu_pkg.sv
// Shared constants for the RAMIO port-A load/store unit: RISC-V funct3
// codes, RAMIO size encodings, FSM states and the split-load extender.
package ramio_lsu_pkg;

    // RISC-V load/store funct3 codes (stores only use the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // RAMIO weA size codes
    localparam logic [1:0] WE_IDLE = 2'b00;
    localparam logic [1:0] WE_BYTE = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

    // RAMIO reA size/sign codes
    localparam logic [2:0] RE_IDLE  = 3'b000;
    localparam logic [2:0] RE_UBYTE = 3'b001;
    localparam logic [2:0] RE_UHALF = 3'b010;
    localparam logic [2:0] RE_SBYTE = 3'b101;
    localparam logic [2:0] RE_SHALF = 3'b110;
    localparam logic [2:0] RE_WORD  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Extends a byte-assembled load. Only halfwords need extension; a split
    // word already fills all 32 bits.
    function automatic logic [31:0] split_extend(input logic [31:0] raw,
                                                 input logic        half,
                                                 input logic        sgn);
        logic [31:0] res;
        res = raw;
        if (half) begin
            res = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ramio_lsu_decode.sv
// Combinational request decoder: funct3 + low address bits -> legality,
// alignment, access size and the RAMIO codes for a single aligned op.
module ramio_lsu_decode
    import ramio_lsu_pkg::*;
(
    input  logic       we_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic       legal_o,
    output logic       aligned_o,
    output logic [2:0] nbytes_o,
    output logic [1:0] we_code_o,
    output logic [2:0] re_code_o,
    output logic       sign_o
);

    // Size/sign lookup, then mask the code for the direction not in use
    always_comb begin
        legal_o   = 1'b0;
        nbytes_o  = 3'd1;
        we_code_o = WE_IDLE;
        re_code_o = RE_IDLE;
        sign_o    = 1'b0;
        case (funct3_i)
            F3_B: begin
                legal_o   = 1'b1;
                nbytes_o  = 3'd1;
                we_code_o = WE_BYTE;
                re_code_o = RE_SBYTE;
                sign_o    = 1'b1;
            end
            F3_H: begin
                legal_o   = 1'b1;
                nbytes_o  = 3'd2;
                we_code_o = WE_HALF;
                re_code_o = RE_SHALF;
                sign_o    = 1'b1;
            end
            F3_W: begin
                legal_o   = 1'b1;
                nbytes_o  = 3'd4;
                we_code_o = WE_WORD;
                re_code_o = RE_WORD;
            end
            F3_BU: begin
                legal_o   = !we_i;
                nbytes_o  = 3'd1;
                re_code_o = RE_UBYTE;
            end
            F3_HU: begin
                legal_o   = !we_i;
                nbytes_o  = 3'd2;
                re_code_o = RE_UHALF;
            end
            default: legal_o = 1'b0;
        endcase
        if (we_i) re_code_o = RE_IDLE;
        else      we_code_o = WE_IDLE;
        if (!legal_o) begin
            we_code_o = WE_IDLE;
            re_code_o = RE_IDLE;
        end
    end

    // Bytes are always aligned; halves need addr[0]=0, words addr[1:0]=0
    always_comb begin
        case (nbytes_o)
            3'd2:    aligned_o = !addr_lo_i[0];
            3'd4:    aligned_o = (addr_lo_i == 2'b00);
            default: aligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ramio_lsu.sv
// Load/store initiator for RAMIO port A. One request per handshake; aligned
// accesses become one RAMIO op, misaligned halves/words become a run of byte
// ops whose load bytes are assembled and extended here. All outputs are
// registered, so each *_d below is the value visible in the next cycle.
module ramio_lsu
    import ramio_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            ram_we,
    output logic [2:0]            ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;       // index of the op being driven
    logic [1:0] last_q;             // index of the final op (N-1, or 0 if aligned)

    // Request captured at handshake
    logic                  st_we_q, st_split_q, st_sign_q;
    logic [1:0]            st_wecode_q;
    logic [2:0]            st_recode_q;
    logic [ADDR_WIDTH-1:0] st_addr_q;
    logic [DATA_WIDTH-1:0] st_wdata_q;
    logic [DATA_WIDTH-1:0] asm_q;   // split-load bytes gathered so far

    // Registered outputs
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            ram_we_q, ram_we_d;
    logic [2:0]            ram_re_q, ram_re_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;

    logic       dec_legal, dec_aligned, dec_sign, dec_split;
    logic [2:0] dec_nbytes;
    logic [1:0] dec_wecode;
    logic [2:0] dec_recode;
    logic       accept;

    ramio_lsu_decode u_decode (
        .we_i      (req_we),
        .funct3_i  (req_funct3),
        .addr_lo_i (req_addr[1:0]),
        .legal_o   (dec_legal),
        .aligned_o (dec_aligned),
        .nbytes_o  (dec_nbytes),
        .we_code_o (dec_wecode),
        .re_code_o (dec_recode),
        .sign_o    (dec_sign)
    );

    assign dec_split = dec_legal && !dec_aligned;
    // req_ready_q is still 0 in the first IDLE cycle after reset
    assign accept    = (state_q == S_IDLE) && req_valid && req_ready_q;

    // The first op is issued on the handshake edge itself, so the op
    // generator reads the live request in IDLE and the captured copy after.
    logic                  cur_we, cur_split;
    logic [1:0]            cur_wecode;
    logic [2:0]            cur_recode;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;

    // Select live or captured request fields
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we     = req_we;
            cur_split  = dec_split;
            cur_wecode = dec_wecode;
            cur_recode = dec_recode;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = st_we_q;
            cur_split  = st_split_q;
            cur_wecode = st_wecode_q;
            cur_recode = st_recode_q;
            cur_addr   = st_addr_q;
            cur_wdata  = st_wdata_q;
        end
    end

    // FSM state and byte counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: illegal requests skip straight to RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 2'd0;
                    state_d = dec_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                if (cnt_q == last_q) state_d = st_we_q ? S_RESP : S_WAIT;
                else                 cnt_d   = cnt_q + 2'd1;
            end
            S_WAIT:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Load result: in WAIT the final byte (or the whole aligned word) is on ram_dout
    logic [DATA_WIDTH-1:0] asm_full, load_res;
    always_comb begin
        asm_full = asm_q;
        asm_full[{cnt_q, 3'b000} +: 8] = ram_dout[7:0];
        load_res = st_split_q ? split_extend(asm_full, last_q == 2'd1, st_sign_q)
                              : ram_dout;
    end

    // FSM outputs: next-cycle values of every registered output
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        ram_we_d    = WE_IDLE;
        ram_re_d    = RE_IDLE;
        ram_addr_d  = '0;
        ram_din_d   = '0;
        if (state_d == S_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = (state_q == S_IDLE);
            if (state_q == S_WAIT) rsp_rdata_d = load_res;
        end
        if (state_d == S_ISSUE) begin
            // address incrementer; wraps naturally at ADDR_WIDTH bits
            ram_addr_d = cur_addr + ADDR_WIDTH'(cnt_d);
            if (cur_split) begin
                if (cur_we) begin
                    ram_we_d  = WE_BYTE;
                    ram_din_d = DATA_WIDTH'(cur_wdata[{cnt_d, 3'b000} +: 8]);
                end else begin
                    ram_re_d  = RE_UBYTE;
                end
            end else begin
                ram_we_d = cur_wecode;
                ram_re_d = cur_recode;
                if (cur_we) ram_din_d = cur_wdata;
            end
        end
    end

    // Output registers; reset forces every output low, aborting any RAM op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ram_we_q    <= WE_IDLE;
            ram_re_q    <= RE_IDLE;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
        end
    end

    // Capture the request on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_we_q     <= 1'b0;
            st_split_q  <= 1'b0;
            st_sign_q   <= 1'b0;
            st_wecode_q <= WE_IDLE;
            st_recode_q <= RE_IDLE;
            st_addr_q   <= '0;
            st_wdata_q  <= '0;
            last_q      <= 2'd0;
        end else if (accept) begin
            st_we_q     <= req_we;
            st_split_q  <= dec_split;
            st_sign_q   <= dec_sign;
            st_wecode_q <= dec_wecode;
            st_recode_q <= dec_recode;
            st_addr_q   <= req_addr;
            st_wdata_q  <= req_wdata;
            last_q      <= dec_split ? 2'(dec_nbytes - 3'd1) : 2'd0;
        end
    end

    // Split-load assembler: byte i arrives while op i+1 is being driven
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= '0;
        end else if (accept) begin
            asm_q <= '0;
        end else if (state_q == S_ISSUE && st_split_q && !st_we_q && cnt_q != 2'd0) begin
            asm_q[{cnt_q - 2'd1, 3'b000} +: 8] <= ram_dout[7:0];
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ramio_lsu.sv
// Bench for ramio_lsu driving a behavioural RAMIO port-A model (byte array,
// little-endian, one-cycle read latency, reads extended by reA code).
module tb_ramio_lsu;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [1:0]    ram_we;
    logic [2:0]    ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout = '0;

    int checks = 0;
    int failures = 0;

    ramio_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAMIO port-A model
    logic [7:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] a0, a1, a2, a3;
    assign a0 = ram_addr;
    assign a1 = ram_addr + 15'd1;
    assign a2 = ram_addr + 15'd2;
    assign a3 = ram_addr + 15'd3;

    always @(posedge clk) begin
        case (ram_we)
            2'b01: mem[a0] <= ram_din[7:0];
            2'b10: begin mem[a0] <= ram_din[7:0]; mem[a1] <= ram_din[15:8]; end
            2'b11: begin
                mem[a0] <= ram_din[7:0];   mem[a1] <= ram_din[15:8];
                mem[a2] <= ram_din[23:16]; mem[a3] <= ram_din[31:24];
            end
            default: ;
        endcase
        case (ram_re)
            3'b001: ram_dout <= {24'h0, mem[a0]};
            3'b101: ram_dout <= {{24{mem[a0][7]}}, mem[a0]};
            3'b010: ram_dout <= {16'h0, mem[a1], mem[a0]};
            3'b110: ram_dout <= {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b111: ram_dout <= {mem[a3], mem[a2], mem[a1], mem[a0]};
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [2:0]    f3;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int            exp_lat;
        int            exp_ops;
    } vec_t;

    // One request; latency counted in cycles after the handshake cycle.
    // Called just after a negedge.
    task automatic do_req(input vec_t v, input string tag);
        int  cyc, ops, bad;
        bit  got;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        cyc = 1; ops = 0; bad = 0; got = 0;
        while (!got && cyc <= 20) begin
            if (ram_we != 2'b00 || ram_re != 3'b000) ops++;
            if (ram_we != 2'b00 && ram_re != 3'b000) bad++;
            if (!v.we && ram_din != 32'h0) bad++;
            if (rsp_valid) got = 1;
            else begin @(negedge clk); cyc++; end
        end
        chk({tag, ".lat"},   cyc, v.exp_lat);
        chk({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, ".err"},   {31'h0, rsp_err}, {31'h0, v.exp_err});
        chk({tag, ".ops"},   ops, v.exp_ops);
        chk({tag, ".excl"},  bad, 0);
        @(negedge clk);
        chk({tag, ".pulse"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, ".idle"},  {31'h0, req_ready}, 32'h1);
    endtask

    vec_t vecs[19];
    vec_t hv;
    int   seen;

    initial begin
        //              we    f3      addr      wdata          exp_rdata     err lat ops
        vecs[0]  = '{1'b1, 3'b010, 15'h0000, 32'h78563412, 32'h00000000, 1'b0, 2, 1};
        vecs[1]  = '{1'b0, 3'b010, 15'h0000, 32'h0,        32'h78563412, 1'b0, 3, 1};
        vecs[2]  = '{1'b1, 3'b001, 15'h0005, 32'h00001234, 32'h00000000, 1'b0, 3, 2};
        vecs[3]  = '{1'b0, 3'b101, 15'h0005, 32'h0,        32'h00001234, 1'b0, 4, 2};
        vecs[4]  = '{1'b1, 3'b010, 15'h0009, 32'hfffefdfc, 32'h00000000, 1'b0, 5, 4};
        vecs[5]  = '{1'b0, 3'b010, 15'h0009, 32'h0,        32'hfffefdfc, 1'b0, 6, 4};
        vecs[6]  = '{1'b0, 3'b000, 15'h0009, 32'h0,        32'hfffffffc, 1'b0, 3, 1};
        vecs[7]  = '{1'b0, 3'b100, 15'h0009, 32'h0,        32'h000000fc, 1'b0, 3, 1};
        vecs[8]  = '{1'b0, 3'b001, 15'h000b, 32'h0,        32'hfffffffe, 1'b0, 4, 2};
        vecs[9]  = '{1'b0, 3'b101, 15'h000b, 32'h0,        32'h0000fffe, 1'b0, 4, 2};
        vecs[10] = '{1'b0, 3'b011, 15'h0000, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[11] = '{1'b1, 3'b100, 15'h0004, 32'hffffffff, 32'h00000000, 1'b1, 1, 0};
        vecs[12] = '{1'b1, 3'b010, 15'h7ffe, 32'haabbccdd, 32'h00000000, 1'b0, 5, 4};
        vecs[13] = '{1'b0, 3'b010, 15'h7ffe, 32'h0,        32'haabbccdd, 1'b0, 6, 4};
        vecs[14] = '{1'b1, 3'b001, 15'h0020, 32'h0000beef, 32'h00000000, 1'b0, 2, 1};
        vecs[15] = '{1'b0, 3'b001, 15'h0020, 32'h0,        32'hffffbeef, 1'b0, 3, 1};
        vecs[16] = '{1'b1, 3'b000, 15'h0030, 32'h000000a5, 32'h00000000, 1'b0, 2, 1};
        vecs[17] = '{1'b0, 3'b000, 15'h0030, 32'h0,        32'hffffffa5, 1'b0, 3, 1};
        vecs[18] = '{1'b1, 3'b010, 15'h0100, 32'h5a5a5a5a, 32'h00000000, 1'b0, 2, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.outs", {req_ready, rsp_valid, rsp_err, ram_we, ram_re} , 32'h0);
        chk("rst.data", rsp_rdata | ram_din | {17'h0, ram_addr}, 32'h0);
        rst = 1'b1;
        #1 chk("rst.ready_hold", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rst.ready_rise", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 19; i++) do_req(vecs[i], $sformatf("v%0d", i));

        // Bytes landed where expected, including across the address wrap
        chk("mem.5",    {24'h0, mem[15'h0005]}, 32'h34);
        chk("mem.6",    {24'h0, mem[15'h0006]}, 32'h12);
        chk("mem.7ffe", {24'h0, mem[15'h7ffe]}, 32'hdd);
        chk("mem.7fff", {24'h0, mem[15'h7fff]}, 32'hcc);
        chk("mem.0",    {24'h0, mem[15'h0000]}, 32'hbb);
        chk("mem.1",    {24'h0, mem[15'h0001]}, 32'haa);

        // Split store @0x101 aborted by reset in cycle 2
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 15'h0101; req_wdata = 32'h44332211;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        chk("abort.c1", {15'h0, ram_addr, ram_we}, {15'h0, 15'h0101, 2'b01});
        @(negedge clk);
        chk("abort.c2", {15'h0, ram_addr, ram_we}, {15'h0, 15'h0102, 2'b01});
        rst = 1'b0;
        #1;
        chk("abort.outs", {req_ready, rsp_valid, rsp_err, ram_we, ram_re}, 32'h0);
        chk("abort.data", rsp_rdata | ram_din | {17'h0, ram_addr}, 32'h0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort.norsp", seen, 0);
        chk("abort.mem101", {24'h0, mem[15'h0101]}, 32'h11);
        chk("abort.mem102", {24'h0, mem[15'h0102]}, 32'h5a);
        rst = 1'b1;
        #1 chk("abort.ready_hold", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("abort.ready_rise", {31'h0, req_ready}, 32'h1);

        // Read back the partially written word
        hv = '{1'b0, 3'b010, 15'h0100, 32'h0, 32'h5a5a115a, 1'b0, 3, 1};
        do_req(hv, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
